pointwise_conv_engine: RTL and testbench

//  Parametrised 1x1 (pointwise) conv engine: y[oc,r,c] = requant(bias[oc] + sum_ic x[ic,r,c]*W[oc,ic]).

---
 rtl/pointwise_conv_engine.sv | 215 +++++++++++++++++++++
 tb/tb_pointwise_conv_engine.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pointwise_conv_engine.sv
// 1x1 convolution engine: OC_PAR output channels per pass over external 1-cycle BRAMs,
// with rounding right-shift requantisation, optional ReLU and signed saturation.
module pointwise_conv_engine #(
    parameter int IN_CHANNELS  = 64,
    parameter int OUT_CHANNELS = 128,
    parameter int HEIGHT       = 7,
    parameter int WIDTH        = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int ACC_WIDTH    = 32,
    parameter int OC_PAR       = 4,
    localparam int HW     = HEIGHT * WIDTH,
    localparam int GROUPS = OUT_CHANNELS / OC_PAR,
    localparam int IA_W   = (IN_CHANNELS * HW > 1) ? $clog2(IN_CHANNELS * HW) : 1,
    localparam int WA_W   = (IN_CHANNELS * GROUPS > 1) ? $clog2(IN_CHANNELS * GROUPS) : 1,
    localparam int BA_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1,
    localparam int OA_W   = (OUT_CHANNELS * HW > 1) ? $clog2(OUT_CHANNELS * HW) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         relu_en,
    input  logic [5:0]                   shift,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_en,
    output logic [IA_W-1:0]              in_addr,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic [WA_W-1:0]              w_addr,
    input  logic [OC_PAR*DATA_WIDTH-1:0] w_data,
    output logic [BA_W-1:0]              b_addr,
    input  logic [OC_PAR*DATA_WIDTH-1:0] b_data,
    output logic                         out_we,
    output logic [OA_W-1:0]              out_addr,
    output logic [DATA_WIDTH-1:0]        out_data
);

    localparam int IC_W = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int PX_W = (HW > 1) ? $clog2(HW) : 1;
    localparam int LN_W = (OC_PAR > 1) ? $clog2(OC_PAR) : 1;
    localparam int PW   = 2 * DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    if (OUT_CHANNELS % OC_PAR != 0) begin : g_oc_par_check
        $error("OUT_CHANNELS must be a multiple of OC_PAR");
    end

    typedef enum logic [2:0] {
        IDLE, BIAS, BIAS_WAIT, MAC, DRAIN, WRITE, NEXT
    } state_t;

    state_t                        state;
    logic [BA_W-1:0]               g;
    logic [PX_W-1:0]               pix;       // r*WIDTH + c, walks rows then cols
    logic [IC_W-1:0]               ic;
    logic [LN_W-1:0]               lane;
    logic [WA_W-1:0]               w_base;
    logic [OA_W-1:0]               o_base;
    logic [5:0]                    shift_q;
    logic                          relu_q;
    logic signed [ACC_WIDTH-1:0]   acc      [OC_PAR];
    logic signed [ACC_WIDTH-1:0]   acc_next [OC_PAR];
    logic signed [PW-1:0]          prod     [OC_PAR];
    logic signed [ACC_WIDTH-1:0]   next_val;

    function automatic logic [DATA_WIDTH-1:0] requant(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic [5:0]                  sh,
        input logic                        relu
    );
        logic signed [ACC_WIDTH-1:0] t;
        logic signed [ACC_WIDTH-1:0] rnd;
        if (sh != 6'd0) begin
            rnd = {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (sh - 6'd1);
            t   = (a + rnd) >>> sh;
        end else begin
            t = a;
        end
        if (relu && t[ACC_WIDTH-1]) t = '0;
        if (t > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
        else if (t < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
        else                  return t[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        for (int unsigned k = 0; k < OC_PAR; k++) begin
            prod[k]     = $signed(in_data) * $signed(w_data[k*DATA_WIDTH +: DATA_WIDTH]);
            acc_next[k] = acc[k] + {{(ACC_WIDTH-PW){prod[k][PW-1]}}, prod[k]};
        end
    end

    // Lane to be presented on the following WRITE cycle.
    always_comb begin
        next_val = '0;
        for (int unsigned k = 0; k < OC_PAR; k++) begin
            if (k == 32'(lane) + 32'd1) next_val = acc[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            in_addr  <= '0;
            w_addr   <= '0;
            b_addr   <= '0;
            out_we   <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
            g        <= '0;
            pix      <= '0;
            ic       <= '0;
            lane     <= '0;
            w_base   <= '0;
            o_base   <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            for (int unsigned k = 0; k < OC_PAR; k++) acc[k] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= BIAS;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        b_addr  <= '0;
                        g       <= '0;
                        pix     <= '0;
                        w_base  <= '0;
                        o_base  <= '0;
                        shift_q <= shift;
                        relu_q  <= relu_en;
                    end
                end
                BIAS: begin
                    state <= BIAS_WAIT;
                    rd_en <= 1'b0;
                end
                BIAS_WAIT: begin
                    for (int unsigned k = 0; k < OC_PAR; k++) begin
                        acc[k] <= {{(ACC_WIDTH-DATA_WIDTH){b_data[k*DATA_WIDTH+DATA_WIDTH-1]}},
                                   b_data[k*DATA_WIDTH +: DATA_WIDTH]};
                    end
                    state   <= MAC;
                    rd_en   <= 1'b1;
                    ic      <= '0;
                    in_addr <= IA_W'(pix);
                    w_addr  <= w_base;
                end
                MAC: begin
                    // Read data trails the address by one cycle, so ic=0 only issues.
                    if (ic != '0) begin
                        for (int unsigned k = 0; k < OC_PAR; k++) acc[k] <= acc_next[k];
                    end
                    if (ic == IC_W'(IN_CHANNELS - 1)) begin
                        state <= DRAIN;
                        rd_en <= 1'b0;
                    end else begin
                        ic      <= ic + IC_W'(1);
                        in_addr <= in_addr + IA_W'(HW);
                        w_addr  <= w_addr + WA_W'(1);
                    end
                end
                DRAIN: begin
                    for (int unsigned k = 0; k < OC_PAR; k++) acc[k] <= acc_next[k];
                    state    <= WRITE;
                    out_we   <= 1'b1;
                    lane     <= '0;
                    out_addr <= o_base + OA_W'(pix);
                    out_data <= requant(acc_next[0], shift_q, relu_q);
                end
                WRITE: begin
                    if (lane == LN_W'(OC_PAR - 1)) begin
                        state  <= NEXT;
                        out_we <= 1'b0;
                    end else begin
                        lane     <= lane + LN_W'(1);
                        out_addr <= out_addr + OA_W'(HW);
                        out_data <= requant(next_val, shift_q, relu_q);
                    end
                end
                NEXT: begin
                    if (pix == PX_W'(HW - 1)) begin
                        pix <= '0;
                        if (g == BA_W'(GROUPS - 1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            g      <= g + BA_W'(1);
                            b_addr <= g + BA_W'(1);
                            w_base <= w_base + WA_W'(IN_CHANNELS);
                            o_base <= o_base + OA_W'(OC_PAR * HW);
                            state  <= BIAS;
                            rd_en  <= 1'b1;
                        end
                    end else begin
                        pix    <= pix + PX_W'(1);
                        b_addr <= g;
                        state  <= BIAS;
                        rd_en  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pointwise_conv_engine.sv
// Directed bench for pointwise_conv_engine: small 4x4 channel, 2x2 map, 2-lane configuration
// with behavioural BRAMs and a write-capture map.
module tb_pointwise_conv_engine;

    localparam int IN  = 4;
    localparam int OUT = 4;
    localparam int H   = 2;
    localparam int W   = 2;
    localparam int OCP = 2;
    localparam int HW  = H * W;
    localparam int NO  = OUT * HW;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        relu_en = 1'b0;
    logic [5:0]  shift = '0;
    logic        busy, done, rd_en, out_we;
    logic [3:0]  in_addr;
    logic [2:0]  w_addr;
    logic [0:0]  b_addr;
    logic [3:0]  out_addr;
    logic [7:0]  in_data, out_data;
    logic [15:0] w_data, b_data;

    logic [7:0]  in_mem [16];
    logic [15:0] w_mem  [8];
    logic [15:0] b_mem  [2];

    logic        clr = 1'b1;
    logic [7:0]  out_mem [NO];
    int          wr_cnt  [NO];
    int          busy_cycles, done_cnt, total_wr;
    int          checks = 0;
    int          errors = 0;

    pointwise_conv_engine #(
        .IN_CHANNELS(IN), .OUT_CHANNELS(OUT), .HEIGHT(H), .WIDTH(W),
        .DATA_WIDTH(8), .ACC_WIDTH(32), .OC_PAR(OCP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .shift(shift),
        .busy(busy), .done(done), .rd_en(rd_en),
        .in_addr(in_addr), .in_data(in_data),
        .w_addr(w_addr), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            in_data <= in_mem[in_addr];
            w_data  <= w_mem[w_addr];
            b_data  <= b_mem[b_addr];
        end
    end

    always @(posedge clk) begin
        if (clr) begin
            busy_cycles <= 0;
            done_cnt    <= 0;
            total_wr    <= 0;
            for (int i = 0; i < NO; i++) begin
                out_mem[i] <= 8'h5A;
                wr_cnt[i]  <= 0;
            end
        end else begin
            if (busy) busy_cycles <= busy_cycles + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (out_we) begin
                out_mem[out_addr] <= out_data;
                wr_cnt[out_addr]  <= wr_cnt[out_addr] + 1;
                total_wr          <= total_wr + 1;
            end
        end
    end

    function automatic int ref_y(int oc, int p, int sh, bit relu);
        int acc, t;
        acc = int'($signed(b_mem[oc / OCP][(oc % OCP) * 8 +: 8]));
        for (int ic = 0; ic < IN; ic++)
            acc += int'($signed(in_mem[ic * HW + p])) *
                   int'($signed(w_mem[(oc / OCP) * IN + ic][(oc % OCP) * 8 +: 8]));
        t = (sh > 0) ? ((acc + (1 << (sh - 1))) >>> sh) : acc;
        if (relu && t < 0) t = 0;
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        return t;
    endfunction

    task automatic fill_const(input logic [7:0] x, input logic [7:0] wv, input logic [7:0] bv);
        for (int i = 0; i < 16; i++) in_mem[i] = x;
        for (int i = 0; i < 8; i++) w_mem[i] = {wv, wv};
        for (int i = 0; i < 2; i++) b_mem[i] = {bv, bv};
    endtask

    task automatic fill_mixed();
        for (int i = 0; i < 16; i++) in_mem[i] = 8'((i * 7) % 23 - 11);
        for (int a = 0; a < 8; a++) w_mem[a] = {8'((a * 5 + 3) % 19 - 9), 8'((a * 11) % 17 - 8)};
        b_mem[0] = {8'(4), 8'(-5)};
        b_mem[1] = {8'(-3), 8'(9)};
    endtask

    // Starts a run with fresh capture statistics and waits (bounded) for done.
    task automatic run(input logic [5:0] sh, input logic relu);
        bit ok;
        @(negedge clk);
        shift = sh; relu_en = relu; start = 1'b1; clr = 1'b1;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (!ok) begin errors++; $display("FAIL run_timeout: done=%b required 1 within 2000 cycles", done); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 6;
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        if (rd_en !== 1'b0)    begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        if (out_we !== 1'b0)   begin errors++; $display("FAIL reset_out_we: got %b want 0", out_we); end
        if ({in_addr, w_addr, b_addr, out_addr} !== '0)
            begin errors++; $display("FAIL reset_addr: got %h want 0", {in_addr, w_addr, b_addr, out_addr}); end
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        rst = 1'b0;
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        fill_const(8'd1, 8'd2, 8'd3);
        run(6'd0, 1'b0);
        for (int a = 0; a < NO; a++) begin
            checks += 2;
            if (out_mem[a] !== 8'd11) begin errors++; $display("FAIL basic_out[%0d]: got %0d want 11", a, $signed(out_mem[a])); end
            if (wr_cnt[a] !== 1) begin errors++; $display("FAIL basic_wrcnt[%0d]: got %0d want 1", a, wr_cnt[a]); end
        end
        checks += 3;
        if (busy_cycles !== 80) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 80", busy_cycles); end
        if (done_cnt !== 1)     begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
        if (total_wr !== NO)    begin errors++; $display("FAIL basic_writes: got %0d want %0d", total_wr, NO); end
    endtask

    task automatic test_saturation();
        fill_const(8'd100, 8'd100, 8'd0);
        run(6'd0, 1'b0);
        for (int a = 0; a < NO; a++) begin
            checks++;
            if (out_mem[a] !== 8'h7F) begin errors++; $display("FAIL sat_pos[%0d]: got %0d want 127", a, $signed(out_mem[a])); end
        end
        fill_const(8'd100, 8'h9C, 8'd0);
        run(6'd0, 1'b0);
        for (int a = 0; a < NO; a++) begin
            checks++;
            if (out_mem[a] !== 8'h80) begin errors++; $display("FAIL sat_neg[%0d]: got %0d want -128", a, $signed(out_mem[a])); end
        end
    endtask

    task automatic test_rounding();
        logic [7:0] exp_oc [OUT];
        fill_const(8'd0, 8'd0, 8'd0);
        b_mem[0] = {8'(-10), 8'(10)};
        b_mem[1] = {8'(7), 8'(6)};
        exp_oc[0] = 8'(3); exp_oc[1] = 8'(-2); exp_oc[2] = 8'(2); exp_oc[3] = 8'(2);
        run(6'd2, 1'b0);
        for (int a = 0; a < NO; a++) begin
            checks++;
            if (out_mem[a] !== exp_oc[a / HW])
                begin errors++; $display("FAIL round[%0d]: got %0d want %0d", a, $signed(out_mem[a]), $signed(exp_oc[a / HW])); end
        end
    endtask

    task automatic test_relu();
        fill_const(8'd0, 8'd0, 8'(-37));
        run(6'd0, 1'b1);
        for (int a = 0; a < NO; a++) begin
            checks++;
            if (out_mem[a] !== 8'h00) begin errors++; $display("FAIL relu_on[%0d]: got %0d want 0", a, $signed(out_mem[a])); end
        end
        run(6'd0, 1'b0);
        for (int a = 0; a < NO; a++) begin
            checks++;
            if (out_mem[a] !== 8'(-37)) begin errors++; $display("FAIL relu_off[%0d]: got %0d want -37", a, $signed(out_mem[a])); end
        end
    endtask

    task automatic test_mixed();
        fill_mixed();
        run(6'd1, 1'b1);
        for (int a = 0; a < NO; a++) begin
            checks++;
            if (out_mem[a] !== 8'(ref_y(a / HW, a % HW, 1, 1'b1)))
                begin errors++; $display("FAIL mixed[%0d]: got %0d want %0d", a, $signed(out_mem[a]), ref_y(a / HW, a % HW, 1, 1'b1)); end
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        fill_mixed();
        @(negedge clk);
        shift = 6'd3; relu_en = 1'b0; start = 1'b1; clr = 1'b1;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (total_wr == 6) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL midrst_wait: writes=%0d required 6", total_wr); end
        repeat (4) @(negedge clk);   // NEXT, BIAS, BIAS_WAIT, MAC ic=0 -> now in MAC ic=1
        rst = 1'b1;
        #1;
        checks += 3;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_busy_done: got %b%b want 00", busy, done); end
        if (rd_en !== 1'b0 || out_we !== 1'b0) begin errors++; $display("FAIL midrst_strobes: got %b%b want 00", rd_en, out_we); end
        if ({in_addr, w_addr, out_addr, out_data} !== '0)
            begin errors++; $display("FAIL midrst_outputs: got %h want 0", {in_addr, w_addr, out_addr, out_data}); end
        repeat (3) @(negedge clk);
        checks++;
        if (total_wr !== 6) begin errors++; $display("FAIL midrst_no_writes: got %0d want 6", total_wr); end
        rst = 1'b0;
        run(6'd3, 1'b0);
        for (int a = 0; a < NO; a++) begin
            checks += 2;
            if (out_mem[a] !== 8'(ref_y(a / HW, a % HW, 3, 1'b0)))
                begin errors++; $display("FAIL restart[%0d]: got %0d want %0d", a, $signed(out_mem[a]), ref_y(a / HW, a % HW, 3, 1'b0)); end
            if (wr_cnt[a] !== 1) begin errors++; $display("FAIL restart_wrcnt[%0d]: got %0d want 1", a, wr_cnt[a]); end
        end
        checks++;
        if (busy_cycles !== 80) begin errors++; $display("FAIL restart_busy_cycles: got %0d want 80", busy_cycles); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        fill_const(8'd1, 8'd2, 8'd3);
        @(negedge clk);
        shift = 6'd0; relu_en = 1'b0; start = 1'b1; clr = 1'b1;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;                // must be ignored while busy
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks += 3;
        if (!ok) begin errors++; $display("FAIL b2b_timeout1: done=%b required 1", done); end
        if (total_wr !== NO) begin errors++; $display("FAIL b2b_writes1: got %0d want %0d", total_wr, NO); end
        if (busy_cycles !== 80) begin errors++; $display("FAIL b2b_busy1: got %0d want 80", busy_cycles); end
        start = 1'b1;                // issued in the done cycle
        clr = 1'b1;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL b2b_timeout2: done=%b required 1", done); end
        if (total_wr !== NO) begin errors++; $display("FAIL b2b_writes2: got %0d want %0d", total_wr, NO); end
        if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done2: got %0d want 1", done_cnt); end
        for (int a = 0; a < NO; a++) begin
            checks++;
            if (out_mem[a] !== 8'd11) begin errors++; $display("FAIL b2b_out[%0d]: got %0d want 11", a, $signed(out_mem[a])); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_relu();
        test_mixed();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
